// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute-stage ALU with valid/ready handshake.
// Logic/arithmetic ops finish in one cycle; shifts iterate one bit per cycle.
`default_nettype none

module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  Cond,
  output logic                  Illegal,
  output logic                  busy
);

  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [SW-1:0]         cnt;
  logic [SW-1:0]         shamt;
  logic                  accept;
  logic                  is_shift;
  logic                  load_result;
  logic [3:0]            flag_op;
  logic [DATA_WIDTH-1:0] comb_result;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0] result_d;

  assign shamt     = SrcB[SW-1:0];
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign is_shift  = (Operation >= 4'd5) && (Operation <= 4'd8);
  assign flag_op   = (state == SHIFT) ? op_q : Operation;

  // Single-cycle result; shift ops land here only with a zero shift amount.
  always_comb begin
    comb_result = '0;
    case (Operation)
      4'b0000: comb_result = SrcA & SrcB;
      4'b0001: comb_result = SrcA | SrcB;
      4'b0010: comb_result = SrcA ^ SrcB;
      4'b0011: comb_result = SrcA + SrcB;
      4'b0100: comb_result = SrcA - SrcB;
      4'b0101, 4'b0110, 4'b0111, 4'b1000: comb_result = SrcA;
      4'b1001: comb_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      4'b1010: comb_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      4'b1011: comb_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) <  $signed(SrcB))};
      4'b1100: comb_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
      4'b1101: comb_result = SrcB;
      default: comb_result = '0;
    endcase
  end

  // SLA keeps the original sign bit in place while the rest shifts left.
  always_comb begin
    shift_next = shreg;
    case (op_q)
      4'b0101: shift_next = {1'b0, shreg[DATA_WIDTH-1:1]};
      4'b0110: shift_next = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
      4'b0111: shift_next = {shreg[DATA_WIDTH-2:0], 1'b0};
      4'b1000: shift_next = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-3:0], 1'b0};
      default: shift_next = shreg;
    endcase
  end

  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    result_d    = comb_result;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            state_next = SHIFT;
          end else begin
            load_result = 1'b1;
            state_next  = DONE;
          end
        end else if ((state == DONE) && out_ready) begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (cnt == SW'(1)) begin
          load_result = 1'b1;
          result_d    = shift_next;
          state_next  = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      shreg     <= '0;
      cnt       <= '0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      Cond      <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q  <= Operation;
        shreg <= SrcA;
        cnt   <= shamt;
      end else if (state == SHIFT) begin
        shreg <= shift_next;
        cnt   <= cnt - SW'(1);
      end
      if (load_result) begin
        ALUResult <= result_d;
        Zero      <= (result_d == '0);
        Cond      <= ((flag_op >= 4'd9) && (flag_op <= 4'd12)) ? result_d[0] : 1'b0;
        Illegal   <= (flag_op >= 4'd14);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against a
// behavioural model of the op-code table and the handshake latency rules.
`default_nettype none

module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Cond;
  logic        Illegal;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero), .Cond(Cond),
    .Illegal(Illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]         s;
    logic signed [31:0] sa;
    s  = b[4:0];
    sa = a;
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a >> s;
      4'd6:    return sa >>> s;
      4'd7:    return a << s;
      4'd8:    return ((a << s) & 32'h7FFF_FFFF) | (a & 32'h8000_0000);
      4'd9:    return (a == b) ? 32'd1 : 32'd0;
      4'd10:   return (a != b) ? 32'd1 : 32'd0;
      4'd11:   return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return (sa >= $signed(b)) ? 32'd1 : 32'd0;
      4'd13:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd5 && op <= 4'd8 && b[4:0] != 5'd0) return int'(b[4:0]);
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation and hold it until the accepting edge, then scramble operands.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic wait_valid(output int lat, output bit ready_seen);
    lat = 0;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    tests++; if (ALUResult !== 32'd0) begin fails++; $display("FAIL reset_result: got %h, required 0", ALUResult); end
    tests++; if ({Zero, Cond, Illegal, busy} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got Z/C/I/busy=%b, required 0000", {Zero, Cond, Illegal, busy}); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    reset = 1'b0;
    tick();
  endtask

  // Runs one op, checks result, flags and latency against the model.
  task automatic test_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    bit          rs;
    logic [31:0] er;
    int          el;
    er = model(op, a, b);
    el = model_lat(op, b);
    issue(op, a, b);
    wait_valid(lat, rs);
    tests++; if (lat != el) begin fails++; $display("FAIL %s_latency: got %0d, required %0d", name, lat, el); end
    tests++; if (ALUResult !== er) begin fails++; $display("FAIL %s_result: got %h, required %h", name, ALUResult, er); end
    tests++; if (Zero !== (er == 32'd0)) begin fails++; $display("FAIL %s_zero: got %b, required %b", name, Zero, er == 32'd0); end
    tests++; if (Cond !== ((op >= 4'd9 && op <= 4'd12) ? er[0] : 1'b0)) begin fails++; $display("FAIL %s_cond: got %b, op %0d result %h", name, Cond, op, er); end
    tests++; if (Illegal !== (op >= 4'd14)) begin fails++; $display("FAIL %s_illegal: got %b, required %b", name, Illegal, op >= 4'd14); end
    if (el > 0) begin
      tests++; if (rs) begin fails++; $display("FAIL %s_in_ready_during_shift: got 1, required 0", name); end
    end
  endtask

  task automatic test_directed();
    test_op("add_ovf", 4'b0011, 32'h7FFF_FFFF, 32'd1);
    test_op("sub_zero", 4'b0100, 32'd5, 32'd5);
    test_op("sra31", 4'b0110, 32'h8000_0000, 32'd31);
    test_op("srl31", 4'b0101, 32'h8000_0000, 32'd31);
    test_op("sla1", 4'b1000, 32'h8000_0001, 32'd1);
    test_op("sll0", 4'b0111, 32'hDEAD_BEEF, 32'h20);
    test_op("slt", 4'b1011, 32'hFFFF_FFFF, 32'd1);
    test_op("bge", 4'b1100, 32'hFFFF_FFFF, 32'd1);
    test_op("beq", 4'b1001, 32'h1234, 32'h1234);
    test_op("illegal", 4'b1110, 32'h5555_5555, 32'h1);
    test_op("lui", 4'b1101, 32'h0, 32'hABCD_E000);
  endtask

  task automatic test_backpressure();
    int lat;
    bit rs;
    tick();  // drain to IDLE
    out_ready = 1'b0;
    issue(4'b0011, 32'd3, 32'd4);
    wait_valid(lat, rs);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd7 || Zero !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d ov=%b res=%h Z=%b ir=%b, required 1/7/0/0", i, out_valid, ALUResult, Zero, in_ready);
      end
    end
    Operation = 4'b0010; SrcA = 32'hF0F0_1234; SrcB = 32'h0FF0_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || ALUResult !== (32'hF0F0_1234 ^ 32'h0FF0_FFFF)) begin
      fails++;
      $display("FAIL b2b_xor: ov=%b res=%h, required 1/%h", out_valid, ALUResult, 32'hF0F0_1234 ^ 32'h0FF0_FFFF);
    end
  endtask

  task automatic test_reset_midshift();
    issue(4'b0111, 32'h0000_0001, 32'd20);
    tick(); tick();
    reset = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midshift_reset: ov=%b busy=%b, required 0/0", out_valid, busy); end
    tick();
    reset = 1'b0;
    test_op("add_after_reset", 4'b0011, 32'd1, 32'd1);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if (op >= 4'd5 && op <= 4'd8 && $urandom_range(0, 1) == 0) b[4:0] = 5'($urandom_range(0, 3));
      test_op("random", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midshift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
